// File: rtl/snapshot_arbiter_pkg.sv
// Shared constants, flit-type encoding and flit-class helpers for the snapshot arbiter
// and the packetizer that consumes its output.
package snapshot_arbiter_pkg;

  localparam int DIAGNOSIS_WB_DATA_WIDTH    = 32;
  localparam int DIAGNOSIS_SNAPSHOT_SOURCES = 2;

  localparam logic [2:0] SNAPSHOT_FLIT_TYPE_NONE   = 3'd0;
  localparam logic [2:0] SNAPSHOT_FLIT_TYPE_SINGLE = 3'd1;
  localparam logic [2:0] SNAPSHOT_FLIT_TYPE_FIRST  = 3'd2;
  localparam logic [2:0] SNAPSHOT_FLIT_TYPE_MIDDLE = 3'd3;
  localparam logic [2:0] SNAPSHOT_FLIT_TYPE_LAST   = 3'd4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Undefined codes end a packet, so anything that is not FIRST/MIDDLE terminates.
  function automatic logic snapshot_flit_is_terminator(input logic [2:0] t);
    return !((t == SNAPSHOT_FLIT_TYPE_FIRST) || (t == SNAPSHOT_FLIT_TYPE_MIDDLE));
  endfunction

  function automatic logic snapshot_flit_is_defined(input logic [2:0] t);
    return (t <= SNAPSHOT_FLIT_TYPE_LAST);
  endfunction

endpackage

// File: rtl/snapshot_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr, wrapping
// modulo PORTS; one-hot grant plus its index.
module snapshot_rr_pick
  import snapshot_arbiter_pkg::*;
#(
  parameter int PORTS     = DIAGNOSIS_SNAPSHOT_SOURCES,
  parameter int SRC_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0]     req,
  input  logic [SRC_WIDTH-1:0] ptr,
  output logic [PORTS-1:0]     gnt,
  output logic [SRC_WIDTH-1:0] idx,
  output logic                 any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      for (int j = 0; j < PORTS; j++) begin
        if (!any && req[j] && (j == ((int'(ptr) + k) % PORTS))) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = SRC_WIDTH'(j);
        end
      end
    end
  end

endmodule

// File: rtl/snapshot_arbiter.sv
// Packet-locked round-robin merge of snapshot flit streams onto one registered output.
//   state      | meaning
//   ARB_IDLE   | unlocked; round-robin from rr_ptr among all valid sources
//   ARB_LOCKED | only lock_src may be granted until it sends a terminator
module snapshot_arbiter
  import snapshot_arbiter_pkg::*;
#(
  parameter int PORTS      = DIAGNOSIS_SNAPSHOT_SOURCES,
  parameter int DATA_WIDTH = DIAGNOSIS_WB_DATA_WIDTH + 1,
  parameter int SRC_WIDTH  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [PORTS*3-1:0]          in_type,
  input  logic [PORTS-1:0]            in_valid,
  output logic [PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [2:0]                  out_type,
  output logic [SRC_WIDTH-1:0]        out_src,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        err
);

  arb_state_e             state_q, state_d;
  logic [SRC_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_WIDTH-1:0]   lock_src_q, lock_src_d;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [2:0]             out_type_q;
  logic [SRC_WIDTH-1:0]   out_src_q;
  logic                   out_valid_q;
  logic                   err_q;

  logic [PORTS-1:0]       lock_mask;
  logic [PORTS-1:0]       pick_req, pick_gnt;
  logic [SRC_WIDTH-1:0]   pick_ptr, pick_idx;
  logic                   pick_any;
  logic                   slot_free, accept;
  logic [2:0]             win_type;
  logic [DATA_WIDTH-1:0]  win_data;
  logic                   win_term, win_defined, proto_err;

  function automatic logic [SRC_WIDTH-1:0] next_ptr(input logic [SRC_WIDTH-1:0] v);
    return (v == SRC_WIDTH'(PORTS - 1)) ? '0 : v + SRC_WIDTH'(1);
  endfunction

  // While locked, the picker sees only the owner's request, so its grant is the owner.
  always_comb begin
    lock_mask = '1;
    pick_ptr  = rr_ptr_q;
    if (state_q == ARB_LOCKED) begin
      lock_mask = PORTS'(1) << lock_src_q;
      pick_ptr  = lock_src_q;
    end
  end

  assign pick_req = in_valid & lock_mask;

  snapshot_rr_pick #(
    .PORTS     (PORTS),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = pick_any && slot_free && !rst;
  assign in_ready  = accept ? pick_gnt : '0;

  always_comb begin
    win_type = SNAPSHOT_FLIT_TYPE_NONE;
    win_data = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (pick_gnt[i]) begin
        win_type = in_type[i*3 +: 3];
        win_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign win_term    = snapshot_flit_is_terminator(win_type);
  assign win_defined = snapshot_flit_is_defined(win_type);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_src_d = lock_src_q;
    proto_err  = 1'b0;
    if (accept) begin
      unique case (state_q)
        ARB_IDLE: begin
          proto_err = (win_type == SNAPSHOT_FLIT_TYPE_MIDDLE) ||
                      (win_type == SNAPSHOT_FLIT_TYPE_LAST) || !win_defined;
          if (win_term) begin
            rr_ptr_d = next_ptr(pick_idx);
          end else begin
            state_d    = ARB_LOCKED;
            lock_src_d = pick_idx;
          end
        end
        ARB_LOCKED: begin
          proto_err = (win_type == SNAPSHOT_FLIT_TYPE_FIRST) || !win_defined;
          if (win_term) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = next_ptr(lock_src_q);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      lock_src_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_type_q  <= SNAPSHOT_FLIT_TYPE_NONE;
      out_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_src_q <= lock_src_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= win_data;
        out_type_q  <= win_type;
        out_src_q   <= pick_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (proto_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_type  = out_type_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_snapshot_arbiter.sv
// Scoreboard bench for snapshot_arbiter: per-source expected flit queues, a packet-level
// lock/error model on the output stream, directed scenarios and a randomized phase.
module tb_snapshot_arbiter;
  import snapshot_arbiter_pkg::*;

  localparam int PORTS = 3;
  localparam int DW    = DIAGNOSIS_WB_DATA_WIDTH + 1;
  localparam int SW    = 2;

  typedef struct packed {
    logic [2:0]    t;
    logic [DW-1:0] d;
  } flit_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [PORTS*DW-1:0]   in_data = '0;
  logic [PORTS*3-1:0]    in_type = '0;
  logic [PORTS-1:0]      in_valid = '0;
  logic [PORTS-1:0]      in_ready;
  logic [DW-1:0]         out_data;
  logic [2:0]            out_type;
  logic [SW-1:0]         out_src;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic                  err;

  always #5 clk = ~clk;

  snapshot_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_type(in_type), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_type(out_type), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  flit_t src_q[PORTS][$];
  flit_t exp_q[PORTS][$];
  int    exp_order[$];
  logic [PORTS-1:0] hold = '0;
  logic [PORTS-1:0] acc_m = '0;
  bit rand_gaps = 0, rand_ready = 0, ready_force = 1;
  int n_checks = 0, n_errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input logic [2:0] t);
    flit_t f;
    f.t = t;
    f.d = DW'({$urandom, $urandom});
    src_q[s].push_back(f);
    exp_q[s].push_back(f);
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < PORTS; i++) n += src_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  // Source drivers: present the head of each source queue, pop it once it was accepted.
  always @(negedge clk) acc_m = in_valid & in_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < PORTS; i++) begin
      if (acc_m[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0 && !hold[i] && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
        in_valid[i]         = 1'b1;
        in_type[i*3 +: 3]   = src_q[i][0].t;
        in_data[i*DW +: DW] = src_q[i][0].d;
      end else begin
        in_valid[i]         = 1'b0;
        in_type[i*3 +: 3]   = 3'($urandom_range(0, 7));
        in_data[i*DW +: DW] = DW'({$urandom, $urandom});
      end
    end
    out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_force;
  end

  // Monitor: per-source ordering, round-robin order, packet integrity, err, stall rules.
  bit            prev_hold = 0;
  logic [DW-1:0] prev_d;
  logic [2:0]    prev_t;
  logic [SW-1:0] prev_s;
  bit            mon_locked = 0;
  int            mon_src = 0;
  bit            err_model = 0;
  flit_t         mf;

  always @(negedge clk) begin
    if (rst) begin
      mon_locked = 0;
      err_model  = 0;
      prev_hold  = 0;
    end else begin
      chk("in_ready_onehot", 64'($countones(in_ready) <= 1), 64'd1);
      if (prev_hold) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(prev_d));
        chk("stall_type", 64'(out_type), 64'(prev_t));
        chk("stall_src", 64'(out_src), 64'(prev_s));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (int'(out_src) >= PORTS || exp_q[out_src].size() == 0) begin
          chk("unexpected_flit_src", 64'(out_src), 64'hFF);
        end else begin
          mf = exp_q[out_src].pop_front();
          chk("flit_type", 64'(out_type), 64'(mf.t));
          chk("flit_data", 64'(out_data), 64'(mf.d));
        end
        if (exp_order.size() > 0) chk("rr_order", 64'(out_src), 64'(exp_order.pop_front()));
        if (mon_locked) chk("no_interleave", 64'(out_src), 64'(mon_src));
        if (out_type > SNAPSHOT_FLIT_TYPE_LAST) err_model = 1;
        if (mon_locked && out_type == SNAPSHOT_FLIT_TYPE_FIRST) err_model = 1;
        if (!mon_locked && (out_type == SNAPSHOT_FLIT_TYPE_MIDDLE ||
                            out_type == SNAPSHOT_FLIT_TYPE_LAST)) err_model = 1;
        if (out_type == SNAPSHOT_FLIT_TYPE_FIRST || out_type == SNAPSHOT_FLIT_TYPE_MIDDLE) begin
          mon_locked = 1;
          mon_src    = int'(out_src);
        end else begin
          mon_locked = 0;
        end
        chk("err_flag", 64'(err), 64'(err_model));
      end
      prev_hold = out_valid && !out_ready;
      prev_d = out_data;
      prev_t = out_type;
      prev_s = out_src;
    end
  end

  task automatic wait_src_empty(input int s);
    int n = 0;
    while (src_q[s].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_src_accept", 64'(src_q[s].size() == 0), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (n < budget && (pending() != 0 || out_valid)) begin
      @(negedge clk);
      n++;
    end
    chk("drain_all_delivered", 64'(pending()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errs++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    logic [2:0]    seq[3];
    logic [DW-1:0] snap_d;
    logic [2:0]    snap_t;
    logic [SW-1:0] snap_s;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_type", 64'(out_type), 64'(SNAPSHOT_FLIT_TYPE_NONE));
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness: every source holds SINGLEs
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < PORTS; s++) begin
        push(s, SNAPSHOT_FLIT_TYPE_SINGLE);
        exp_order.push_back(s);
      end
    wait_drain(100);

    // Single source three-flit packet, one-cycle latency
    push(0, SNAPSHOT_FLIT_TYPE_FIRST);
    push(0, SNAPSHOT_FLIT_TYPE_MIDDLE);
    push(0, SNAPSHOT_FLIT_TYPE_LAST);
    repeat (3) exp_order.push_back(0);
    seq[0] = SNAPSHOT_FLIT_TYPE_FIRST;
    seq[1] = SNAPSHOT_FLIT_TYPE_MIDDLE;
    seq[2] = SNAPSHOT_FLIT_TYPE_LAST;
    n = 0;
    while (!(in_valid[0] && in_ready[0]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ss_first_accepted", 64'(n < 20), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ss_out_valid", 64'(out_valid), 64'd1);
      chk("ss_out_src", 64'(out_src), 64'd0);
      chk("ss_out_type", 64'(out_type), 64'(seq[k]));
    end
    wait_drain(50);

    // Lock held across a stalled source
    exp_order.push_back(0);
    exp_order.push_back(0);
    exp_order.push_back(1);
    push(0, SNAPSHOT_FLIT_TYPE_FIRST);
    wait_src_empty(0);
    push(1, SNAPSHOT_FLIT_TYPE_SINGLE);
    repeat (4) begin
      @(negedge clk);
      chk("lock_blocks_other", 64'(in_ready[1]), 64'd0);
    end
    push(0, SNAPSHOT_FLIT_TYPE_LAST);
    @(negedge clk);
    chk("lock_last_accept", 64'(in_ready), 64'b001);
    @(negedge clk);
    chk("lock_release_next", 64'(in_ready), 64'b010);
    wait_drain(50);

    // Back-pressure mid-packet
    push(0, SNAPSHOT_FLIT_TYPE_FIRST);
    repeat (3) push(0, SNAPSHOT_FLIT_TYPE_MIDDLE);
    push(0, SNAPSHOT_FLIT_TYPE_LAST);
    n = 0;
    while (src_q[0].size() > 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ready_force = 0;
    @(negedge clk);
    snap_d = out_data;
    snap_t = out_type;
    snap_s = out_src;
    chk("bp_valid_at_stall", 64'(out_valid), 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_data", 64'(out_data), 64'(snap_d));
      chk("bp_hold_type", 64'(out_type), 64'(snap_t));
      chk("bp_hold_src", 64'(out_src), 64'(snap_s));
      chk("bp_in_ready_zero", 64'(in_ready), 64'd0);
    end
    ready_force = 1;
    wait_drain(50);

    // NONE marker, then MIDDLE from IDLE (protocol error that locks)
    push(1, SNAPSHOT_FLIT_TYPE_NONE);
    wait_src_empty(1);
    chk("none_on_output", 64'(out_type), 64'(SNAPSHOT_FLIT_TYPE_NONE));
    chk("none_no_err", 64'(err), 64'd0);
    ready_force = 0;
    push(1, SNAPSHOT_FLIT_TYPE_MIDDLE);
    wait_src_empty(1);
    chk("mid_err_set", 64'(err), 64'd1);
    chk("mid_out_src", 64'(out_src), 64'd1);
    push(0, SNAPSHOT_FLIT_TYPE_SINGLE);
    push(2, SNAPSHOT_FLIT_TYPE_SINGLE);
    ready_force = 1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_locked_src1", 64'(in_ready), 64'd0);
    end
    ready_force = 0;
    push(1, SNAPSHOT_FLIT_TYPE_MIDDLE);
    wait_src_empty(1);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);

    // Reset while locked with a flit held in the output register
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q[1].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    ready_force = 1;
    exp_order.push_back(0);
    exp_order.push_back(2);
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_err", 64'(err), 64'd0);
    chk("mrst_out_type", 64'(out_type), 64'(SNAPSHOT_FLIT_TYPE_NONE));
    chk("mrst_rr_ptr_zero", 64'(in_ready), 64'b001);
    wait_drain(50);

    // Randomized well-formed packets with gaps and random back-pressure
    rand_gaps  = 1;
    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      int s, len;
      s   = $urandom_range(0, PORTS - 1);
      len = $urandom_range(1, 5);
      if (len == 1) begin
        push(s, ($urandom_range(0, 1) != 0) ? SNAPSHOT_FLIT_TYPE_SINGLE : SNAPSHOT_FLIT_TYPE_NONE);
      end else begin
        push(s, SNAPSHOT_FLIT_TYPE_FIRST);
        for (int m = 0; m < len - 2; m++) push(s, SNAPSHOT_FLIT_TYPE_MIDDLE);
        push(s, SNAPSHOT_FLIT_TYPE_LAST);
      end
    end
    wait_drain(4000);
    rand_gaps  = 0;
    rand_ready = 0;
    chk("random_no_err", 64'(err), 64'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
